// File: rtl/reorder_buffer_param.sv
// Circular reorder buffer: in-order allocate, out-of-order completion from N_CDB
// broadcast channels, in-order single commit, full flush on a mispredicted head branch.
module reorder_buffer_param #(
  parameter int DEPTH = 32,
  parameter int XLEN  = 32,
  parameter int N_CDB = 7,
  parameter int REG_W = 5,
  parameter int TAG_W = $clog2(DEPTH + 1)
) (
  input  logic                   CLOCK_50,
  input  logic                   RSTN_N,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic                   alloc_is_store_i,
  input  logic                   alloc_is_branch_i,
  input  logic [REG_W-1:0]       alloc_rd_i,
  output logic [TAG_W-1:0]       alloc_tag_o,
  input  logic [N_CDB-1:0]       cdb_valid_i,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag_i,
  input  logic [N_CDB*XLEN-1:0]  cdb_value_i,
  input  logic [N_CDB*XLEN-1:0]  cdb_addr_i,
  input  logic [N_CDB-1:0]       cdb_mispred_i,
  input  logic [2*TAG_W-1:0]     src_tag_i,
  output logic [1:0]             src_ready_o,
  output logic [2*XLEN-1:0]      src_value_o,
  output logic                   commit_valid_o,
  output logic                   commit_is_store_o,
  output logic [REG_W-1:0]       commit_rd_o,
  output logic [TAG_W-1:0]       commit_tag_o,
  output logic [XLEN-1:0]        commit_value_o,
  output logic [XLEN-1:0]        commit_addr_o,
  output logic                   flush_o
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q    [DEPTH];
  logic             is_store_q [DEPTH];
  logic             is_branch_q[DEPTH];
  logic             mispred_q  [DEPTH];
  logic [REG_W-1:0] rd_q       [DEPTH];
  logic [XLEN-1:0]  value_q    [DEPTH];
  logic [XLEN-1:0]  addr_q     [DEPTH];

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [TAG_W-1:0] count_q;

  logic [DEPTH-1:0] cdb_hit;
  logic [XLEN-1:0]  cdb_val [DEPTH];
  logic [XLEN-1:0]  cdb_adr [DEPTH];
  logic             cdb_mp  [DEPTH];

  logic head_done;
  logic do_flush;
  logic do_commit;
  logic do_alloc;

  assign alloc_ready_o = (count_q != TAG_W'(DEPTH));
  assign alloc_tag_o   = {1'b0, tail_q} + TAG_W'(1);

  assign head_done = (state_q[head_q] == ST_DONE);
  assign do_flush  = head_done && is_branch_q[head_q] && mispred_q[head_q];
  assign do_commit = head_done && !do_flush;
  assign do_alloc  = alloc_valid_i && alloc_ready_o;

  // Per-entry CDB match; scanning channels downwards lets the lowest index win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cdb_hit[i] = 1'b0;
      cdb_val[i] = '0;
      cdb_adr[i] = '0;
      cdb_mp[i]  = 1'b0;
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == TAG_W'(i + 1))) begin
          cdb_hit[i] = 1'b1;
          cdb_val[i] = cdb_value_i[k*XLEN +: XLEN];
          cdb_adr[i] = cdb_addr_i[k*XLEN +: XLEN];
          cdb_mp[i]  = cdb_mispred_i[k];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_lookup
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             rdy;
    logic [XLEN-1:0]  val;

    assign tag = src_tag_i[p*TAG_W +: TAG_W];
    assign idx = IDX_W'(tag - TAG_W'(1));

    // Tags beyond DEPTH name no entry and are never ready.
    always_comb begin
      rdy = 1'b0;
      val = '0;
      if (tag == '0) begin
        rdy = 1'b1;
      end else if (tag <= TAG_W'(DEPTH)) begin
        if (state_q[idx] == ST_DONE) begin
          rdy = 1'b1;
          val = value_q[idx];
        end else if ((state_q[idx] == ST_PEND) && cdb_hit[idx]) begin
          rdy = 1'b1;
          val = cdb_val[idx];
        end
      end
    end

    assign src_ready_o[p]             = rdy;
    assign src_value_o[p*XLEN +: XLEN] = val;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RSTN_N) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      commit_valid_o    <= 1'b0;
      commit_is_store_o <= 1'b0;
      commit_rd_o       <= '0;
      commit_tag_o      <= '0;
      commit_value_o    <= '0;
      commit_addr_o     <= '0;
      flush_o           <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]     <= ST_FREE;
        is_store_q[i]  <= 1'b0;
        is_branch_q[i] <= 1'b0;
        mispred_q[i]   <= 1'b0;
        rd_q[i]        <= '0;
        value_q[i]     <= '0;
        addr_q[i]      <= '0;
      end
    end else if (do_flush) begin
      // Same-edge alloc and CDB writes are dropped along with everything else.
      flush_o        <= 1'b1;
      commit_valid_o <= 1'b0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
      end
    end else begin
      flush_o        <= 1'b0;
      commit_valid_o <= do_commit;
      for (int i = 0; i < DEPTH; i++) begin
        if ((state_q[i] == ST_PEND) && cdb_hit[i]) begin
          state_q[i]   <= ST_DONE;
          value_q[i]   <= cdb_val[i];
          addr_q[i]    <= cdb_adr[i];
          mispred_q[i] <= cdb_mp[i];
        end
      end
      if (do_commit) begin
        commit_is_store_o <= is_store_q[head_q];
        commit_rd_o       <= rd_q[head_q];
        commit_tag_o      <= {1'b0, head_q} + TAG_W'(1);
        commit_value_o    <= value_q[head_q];
        commit_addr_o     <= addr_q[head_q];
        state_q[head_q]   <= ST_FREE;
        head_q            <= head_q + IDX_W'(1);
      end
      if (do_alloc) begin
        state_q[tail_q]     <= ST_PEND;
        is_store_q[tail_q]  <= alloc_is_store_i;
        is_branch_q[tail_q] <= alloc_is_branch_i;
        mispred_q[tail_q]   <= 1'b0;
        rd_q[tail_q]        <= alloc_rd_i;
        tail_q              <= tail_q + IDX_W'(1);
      end
      count_q <= count_q + TAG_W'(do_alloc) - TAG_W'(do_commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Self-checking bench for reorder_buffer_param (DEPTH=4): commit scoreboard,
// table-driven lookup/bypass vectors and hand-written full/wrap/flush sequences.
module tb_reorder_buffer_param;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int N_CDB = 7;
  localparam int REG_W = 5;
  localparam int TAG_W = 3;

  logic                   CLOCK_50;
  logic                   RSTN_N;
  logic                   alloc_valid_i;
  logic                   alloc_ready_o;
  logic                   alloc_is_store_i;
  logic                   alloc_is_branch_i;
  logic [REG_W-1:0]       alloc_rd_i;
  logic [TAG_W-1:0]       alloc_tag_o;
  logic [N_CDB-1:0]       cdb_valid_i;
  logic [N_CDB*TAG_W-1:0] cdb_tag_i;
  logic [N_CDB*XLEN-1:0]  cdb_value_i;
  logic [N_CDB*XLEN-1:0]  cdb_addr_i;
  logic [N_CDB-1:0]       cdb_mispred_i;
  logic [2*TAG_W-1:0]     src_tag_i;
  logic [1:0]             src_ready_o;
  logic [2*XLEN-1:0]      src_value_o;
  logic                   commit_valid_o;
  logic                   commit_is_store_o;
  logic [REG_W-1:0]       commit_rd_o;
  logic [TAG_W-1:0]       commit_tag_o;
  logic [XLEN-1:0]        commit_value_o;
  logic [XLEN-1:0]        commit_addr_o;
  logic                   flush_o;

  reorder_buffer_param #(
    .DEPTH(DEPTH), .XLEN(XLEN), .N_CDB(N_CDB), .REG_W(REG_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_is_store_i(alloc_is_store_i), .alloc_is_branch_i(alloc_is_branch_i),
    .alloc_rd_i(alloc_rd_i), .alloc_tag_o(alloc_tag_o),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .cdb_addr_i(cdb_addr_i), .cdb_mispred_i(cdb_mispred_i),
    .src_tag_i(src_tag_i), .src_ready_o(src_ready_o), .src_value_o(src_value_o),
    .commit_valid_o(commit_valid_o), .commit_is_store_o(commit_is_store_o),
    .commit_rd_o(commit_rd_o), .commit_tag_o(commit_tag_o),
    .commit_value_o(commit_value_o), .commit_addr_o(commit_addr_o),
    .flush_o(flush_o)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] rd;
    logic             st;
  } sb_rec_t;

  typedef struct {
    int               ch;
    logic [TAG_W-1:0] ctag;
    logic [XLEN-1:0]  cval;
    logic [TAG_W-1:0] s0;
    logic [TAG_W-1:0] s1;
    logic [1:0]       rdy;
    logic [XLEN-1:0]  v0;
    logic [XLEN-1:0]  v1;
  } lk_row_t;

  sb_rec_t          sb_q[$];
  sb_rec_t          mon_rec;
  logic [XLEN-1:0]  m_val [8];
  logic [XLEN-1:0]  m_addr[8];
  logic [TAG_W-1:0] exp_next_tag;
  logic             flush_ok;
  lk_row_t          lk_tab[7];
  logic [TAG_W-1:0] st_tag;
  int               total_cnt;
  int               bad_cnt;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Commits are popped in order from the scoreboard; flush_o is only legal when armed.
  always @(negedge CLOCK_50) begin
    if (RSTN_N === 1'b1) begin
      if (!flush_ok) checkOutput("no_flush", flush_o, 1'b0);
      if (commit_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("commit_with_empty_sb", commit_valid_o, 1'b0);
        end else begin
          mon_rec = sb_q.pop_front();
          checkOutput("commit_tag", commit_tag_o, mon_rec.tag);
          checkOutput("commit_rd", commit_rd_o, mon_rec.rd);
          checkOutput("commit_is_store", commit_is_store_o, mon_rec.st);
          checkOutput("commit_value", commit_value_o, m_val[mon_rec.tag]);
          if (mon_rec.st) checkOutput("commit_addr", commit_addr_o, m_addr[mon_rec.tag]);
        end
      end
    end
  end

  task automatic clear_inputs();
    alloc_valid_i = 1'b0; alloc_is_store_i = 1'b0; alloc_is_branch_i = 1'b0;
    alloc_rd_i = '0; cdb_valid_i = '0; cdb_tag_i = '0; cdb_value_i = '0;
    cdb_addr_i = '0; cdb_mispred_i = '0; src_tag_i = '0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RSTN_N = 1'b0;
    clear_inputs();
    sb_q.delete();
    exp_next_tag = 1;
    flush_ok = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_alloc_ready", alloc_ready_o, 1'b1);
    checkOutput("rst_alloc_tag", alloc_tag_o, 1);
    checkOutput("rst_commit_valid", commit_valid_o, 1'b0);
    checkOutput("rst_flush", flush_o, 1'b0);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
  endtask

  task automatic alloc_one(input logic [REG_W-1:0] rd, input logic st, input logic br);
    sb_rec_t rec;
    @(negedge CLOCK_50);
    alloc_valid_i = 1'b1; alloc_rd_i = rd; alloc_is_store_i = st; alloc_is_branch_i = br;
    #1;
    checkOutput("alloc_ready", alloc_ready_o, 1'b1);
    checkOutput("alloc_tag", alloc_tag_o, exp_next_tag);
    rec.tag = exp_next_tag; rec.rd = rd; rec.st = st;
    sb_q.push_back(rec);
    exp_next_tag = (exp_next_tag == TAG_W'(DEPTH)) ? TAG_W'(1) : exp_next_tag + TAG_W'(1);
    @(posedge CLOCK_50);
    #1;
    alloc_valid_i = 1'b0; alloc_is_store_i = 1'b0; alloc_is_branch_i = 1'b0;
  endtask

  task automatic cdb_one(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                         input logic [XLEN-1:0] addr, input logic mp);
    @(negedge CLOCK_50);
    cdb_valid_i = '0; cdb_mispred_i = '0;
    cdb_valid_i[ch] = 1'b1;
    cdb_tag_i[ch*TAG_W +: TAG_W] = tag;
    cdb_value_i[ch*XLEN +: XLEN] = val;
    cdb_addr_i[ch*XLEN +: XLEN] = addr;
    cdb_mispred_i[ch] = mp;
    m_val[tag] = val;
    m_addr[tag] = addr;
    @(posedge CLOCK_50);
    #1;
    cdb_valid_i = '0; cdb_mispred_i = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge CLOCK_50);
      #1;
      c++;
    end
    checkOutput(name, sb_q.size(), 0);
  endtask

  // Lookup rows are driven mid-cycle and withdrawn before the edge, so nothing is written.
  task automatic applyStimulus(input int idx, input lk_row_t r);
    @(negedge CLOCK_50);
    cdb_valid_i = '0; cdb_mispred_i = '0;
    if (r.ch >= 0) begin
      cdb_valid_i[r.ch] = 1'b1;
      cdb_tag_i[r.ch*TAG_W +: TAG_W] = r.ctag;
      cdb_value_i[r.ch*XLEN +: XLEN] = r.cval;
    end
    src_tag_i = {r.s1, r.s0};
    #1;
    checkOutput($sformatf("lk%0d_ready", idx), src_ready_o, r.rdy);
    checkOutput($sformatf("lk%0d_value0", idx), src_value_o[XLEN-1:0], r.v0);
    checkOutput($sformatf("lk%0d_value1", idx), src_value_o[2*XLEN-1:XLEN], r.v1);
    cdb_valid_i = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total_cnt = 0;
    bad_cnt = 0;
    RSTN_N = 1'b0;
    flush_ok = 1'b0;
    exp_next_tag = 1;
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = '0;
      m_addr[i] = '0;
    end

    // State for the table: tag1/tag3 pending, tag2 done = 0x22, tag4 free.
    lk_tab[0] = '{-1, 3'd0, 32'h00, 3'd0, 3'd2, 2'b11, 32'h00, 32'h22};
    lk_tab[1] = '{-1, 3'd0, 32'h00, 3'd1, 3'd3, 2'b00, 32'h00, 32'h00};
    lk_tab[2] = '{ 3, 3'd1, 32'h11, 3'd1, 3'd3, 2'b01, 32'h11, 32'h00};
    lk_tab[3] = '{ 6, 3'd3, 32'h33, 3'd3, 3'd1, 2'b01, 32'h33, 32'h00};
    lk_tab[4] = '{ 0, 3'd2, 32'h99, 3'd2, 3'd4, 2'b01, 32'h22, 32'h00};
    lk_tab[5] = '{ 1, 3'd4, 32'h44, 3'd4, 3'd0, 2'b10, 32'h00, 32'h00};
    lk_tab[6] = '{-1, 3'd0, 32'h00, 3'd6, 3'd7, 2'b00, 32'h00, 32'h00};

    do_reset();

    alloc_one(5'd5, 1'b0, 1'b0);
    alloc_one(5'd6, 1'b0, 1'b0);
    alloc_one(5'd7, 1'b0, 1'b0);
    cdb_one(0, 3'd3, 32'd30, 32'd0, 1'b0);
    cdb_one(1, 3'd1, 32'd10, 32'd0, 1'b0);
    cdb_one(2, 3'd2, 32'd20, 32'd0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge CLOCK_50);
      #1;
      checkOutput($sformatf("retire_pulse%0d", j), commit_valid_o, 1'b1);
    end
    @(negedge CLOCK_50);
    #1;
    checkOutput("retire_stop", commit_valid_o, 1'b0);
    wait_idle("retire_drain", 10);

    st_tag = exp_next_tag;
    alloc_one(5'd9, 1'b1, 1'b0);
    cdb_one(1, st_tag, 32'hAB, 32'h40, 1'b0);
    @(negedge CLOCK_50);
    #1;
    checkOutput("store_not_early", commit_valid_o, 1'b0);
    @(negedge CLOCK_50);
    #1;
    checkOutput("store_latency", commit_valid_o, 1'b1);
    checkOutput("store_is_store", commit_is_store_o, 1'b1);
    checkOutput("store_value", commit_value_o, 32'hAB);
    checkOutput("store_addr", commit_addr_o, 32'h40);
    wait_idle("store_drain", 10);

    do_reset();
    alloc_one(5'd1, 1'b0, 1'b0);
    alloc_one(5'd2, 1'b0, 1'b0);
    alloc_one(5'd3, 1'b0, 1'b0);
    cdb_one(0, 3'd2, 32'h22, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(i, lk_tab[i]);

    @(negedge CLOCK_50);
    cdb_valid_i = '0;
    cdb_valid_i[2] = 1'b1; cdb_tag_i[2*TAG_W +: TAG_W] = 3'd1; cdb_value_i[2*XLEN +: XLEN] = 32'd7;
    cdb_valid_i[5] = 1'b1; cdb_tag_i[5*TAG_W +: TAG_W] = 3'd1; cdb_value_i[5*XLEN +: XLEN] = 32'd9;
    src_tag_i = {3'd0, 3'd1};
    m_val[1] = 32'd7;
    #1;
    checkOutput("conflict_ready", src_ready_o[0], 1'b1);
    checkOutput("conflict_value", src_value_o[XLEN-1:0], 32'd7);
    @(posedge CLOCK_50);
    #1;
    cdb_valid_i = '0;
    cdb_one(4, 3'd3, 32'h33, 32'd0, 1'b0);
    wait_idle("conflict_drain", 10);

    do_reset();
    for (int j = 0; j < 4; j++) alloc_one(REG_W'(j + 1), 1'b0, 1'b0);
    @(negedge CLOCK_50);
    #1;
    checkOutput("full_ready", alloc_ready_o, 1'b0);
    alloc_valid_i = 1'b1; alloc_rd_i = 5'd10;
    cdb_valid_i = '0;
    cdb_valid_i[0] = 1'b1; cdb_tag_i[0 +: TAG_W] = 3'd1; cdb_value_i[0 +: XLEN] = 32'h101;
    m_val[1] = 32'h101;
    @(posedge CLOCK_50);
    #1;
    cdb_valid_i = '0;
    @(negedge CLOCK_50);
    #1;
    checkOutput("full_hold_ready", alloc_ready_o, 1'b0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #1;
    checkOutput("wrap_ready", alloc_ready_o, 1'b1);
    checkOutput("wrap_tag", alloc_tag_o, 1);
    mon_rec.tag = exp_next_tag; mon_rec.rd = 5'd10; mon_rec.st = 1'b0;
    sb_q.push_back(mon_rec);
    exp_next_tag = (exp_next_tag == TAG_W'(DEPTH)) ? TAG_W'(1) : exp_next_tag + TAG_W'(1);
    @(posedge CLOCK_50);
    #1;
    alloc_valid_i = 1'b0;
    @(negedge CLOCK_50);
    #1;
    checkOutput("refull_ready", alloc_ready_o, 1'b0);
    cdb_one(1, 3'd2, 32'h102, 32'd0, 1'b0);
    cdb_one(2, 3'd3, 32'h103, 32'd0, 1'b0);
    cdb_one(3, 3'd4, 32'h104, 32'd0, 1'b0);
    cdb_one(4, 3'd1, 32'h110, 32'd0, 1'b0);
    wait_idle("wrap_drain", 12);

    do_reset();
    alloc_one(5'd1, 1'b0, 1'b1);
    alloc_one(5'd2, 1'b0, 1'b0);
    alloc_one(5'd3, 1'b0, 1'b0);
    cdb_one(0, 3'd2, 32'h2, 32'd0, 1'b0);
    cdb_one(0, 3'd3, 32'h3, 32'd0, 1'b0);
    flush_ok = 1'b1;
    cdb_one(1, 3'd1, 32'h0, 32'd0, 1'b1);
    @(negedge CLOCK_50);
    #1;
    checkOutput("flush_early", flush_o, 1'b0);
    alloc_valid_i = 1'b1; alloc_rd_i = 5'd20;
    @(posedge CLOCK_50);
    #1;
    alloc_valid_i = 1'b0;
    sb_q.delete();
    exp_next_tag = 1;
    @(negedge CLOCK_50);
    #1;
    checkOutput("flush_pulse", flush_o, 1'b1);
    checkOutput("flush_no_commit", commit_valid_o, 1'b0);
    checkOutput("flush_alloc_tag", alloc_tag_o, 1);
    checkOutput("flush_alloc_ready", alloc_ready_o, 1'b1);
    @(negedge CLOCK_50);
    #1;
    checkOutput("flush_one_cycle", flush_o, 1'b0);
    flush_ok = 1'b0;
    alloc_one(5'd4, 1'b0, 1'b0);
    cdb_one(2, 3'd1, 32'h55, 32'd0, 1'b0);
    wait_idle("flush_drain", 10);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
